// File: rtl/ddr2_arb_pkg.sv
// rtl/ddr2_arb_pkg.sv - shared widths, FSM states and command record for the DDR2 local arbiter
package ddr2_arb_pkg;

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE
  } arb_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic                  wr;
    logic                  id;
  } arb_cmd_t;

endpackage

// File: rtl/ddr2_tag_fifo.sv
// rtl/ddr2_tag_fifo.sv - in-order 1-bit client-id FIFO for outstanding reads
module ddr2_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + (PW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ddr2_local_arbiter.sv
// rtl/ddr2_local_arbiter.sv - two-client round-robin arbiter in front of the DDR2 controller local interface
module ddr2_local_arbiter
  import ddr2_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              wr_0,
  input  logic              wr_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              ack_0,
  output logic              ack_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] local_address,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic [DATA_W-1:0] local_wdata,
  input  logic              local_ready,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid,
  input  logic              local_init_done,
  output logic              tag_err
);

  arb_state_t state_q, state_d;
  arb_cmd_t   cmd_q, cmd_d;
  logic       prio_q, prio_d;
  logic       ack_0_q, ack_1_q;
  logic       tag_err_q;
  logic       grant, gnt_id;
  logic       elig_0, elig_1;
  logic       tag_push;
  logic       fifo_full, fifo_empty, fifo_head;
  logic       issuing;

  // A read needs a free tag slot; writes never do.
  assign elig_0 = req_0 & (wr_0 | ~fifo_full);
  assign elig_1 = req_1 & (wr_1 | ~fifo_full);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    prio_d   = prio_q;
    grant    = 1'b0;
    gnt_id   = 1'b0;
    tag_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (local_init_done) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!local_init_done) begin
          state_d = ST_IDLE;
        end else if (elig_0 | elig_1) begin
          grant       = 1'b1;
          gnt_id      = (elig_0 & elig_1) ? prio_q : elig_1;
          cmd_d.addr  = gnt_id ? DEF_ADDR_W'(addr_1)  : DEF_ADDR_W'(addr_0);
          cmd_d.wdata = gnt_id ? DEF_DATA_W'(wdata_1) : DEF_DATA_W'(wdata_0);
          cmd_d.wr    = gnt_id ? wr_1 : wr_0;
          cmd_d.id    = gnt_id;
          prio_d      = ~gnt_id;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (local_ready) begin
          tag_push = ~cmd_q.wr;
          state_d  = local_init_done ? ST_ARB : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      prio_q    <= 1'b0;
      ack_0_q   <= 1'b0;
      ack_1_q   <= 1'b0;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      prio_q    <= prio_d;
      ack_0_q   <= grant & ~gnt_id;
      ack_1_q   <= grant & gnt_id;
      tag_err_q <= tag_err_q | (local_rdata_valid & fifo_empty);
    end
  end

  ddr2_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tag_push),
    .push_data_i (cmd_q.id),
    .pop_i       (local_rdata_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign issuing         = (state_q == ST_ISSUE);
  assign local_write_req = issuing & cmd_q.wr;
  assign local_read_req  = issuing & ~cmd_q.wr;
  assign local_address   = ADDR_W'(cmd_q.addr);
  assign local_wdata     = DATA_W'(cmd_q.wdata);

  assign ack_0    = ack_0_q;
  assign ack_1    = ack_1_q;
  assign tag_err  = tag_err_q;
  assign rdata    = local_rdata;
  assign rvalid_0 = local_rdata_valid & ~fifo_empty & ~fifo_head;
  assign rvalid_1 = local_rdata_valid & ~fifo_empty & fifo_head;

endmodule
